// File: rtl/spiker_writer.sv
// Captures a spike result vector on a valid/ready handshake and streams it into the
// register file one WIDTH-bit word per cycle, then pulses done and counts the frame.
module spiker_writer #(
  parameter int WIDTH    = 32,
  parameter int N_SPIKES = 784,
  localparam int N_WORDS = (N_SPIKES + WIDTH - 1) / WIDTH,
  localparam int IDX_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                enable_i,
  input  logic                result_valid_i,
  input  logic [N_SPIKES-1:0] result_i,
  output logic                result_ready_o,
  output logic                wr_en_o,
  output logic [IDX_W-1:0]    wr_idx_o,
  output logic [WIDTH-1:0]    wr_data_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [15:0]         frame_cnt_o
);

  localparam int TOT_W = N_WORDS * WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [TOT_W-1:0] shadow_q, shadow_d;
  logic             wr_en_q, wr_en_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [15:0]      frame_q, frame_d;

  logic [TOT_W-1:0] result_pad_s;
  logic [IDX_W-1:0] nxt_idx_s;
  int               nxt_off_s;
  logic [WIDTH-1:0] nxt_word_s;

  assign result_ready_o = (state_q == IDLE) & enable_i;

  // Zero-extend the incoming vector to whole words and pick the next word to emit.
  always_comb begin
    result_pad_s                 = '0;
    result_pad_s[N_SPIKES-1:0]   = result_i;
    nxt_idx_s                    = cnt_q + IDX_W'(1);
    nxt_off_s                    = int'(nxt_idx_s) * WIDTH;
    nxt_word_s                   = shadow_q[nxt_off_s +: WIDTH];
  end

  // Next-state logic; write-port outputs are computed one cycle ahead so they leave registered.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    wr_en_d   = 1'b0;
    wr_idx_d  = '0;
    wr_data_d = '0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    frame_d   = frame_q;
    case (state_q)
      IDLE: begin
        if (result_valid_i && result_ready_o) begin
          state_d   = WRITE;
          cnt_d     = '0;
          shadow_d  = result_pad_s;
          wr_en_d   = 1'b1;
          wr_data_d = result_pad_s[WIDTH-1:0];
          busy_d    = 1'b1;
        end else begin
          busy_d    = 1'b0;
        end
      end
      WRITE: begin
        if (!enable_i) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else if (cnt_q == LAST_IDX) begin
          state_d = DONE;
          done_d  = 1'b1;
          frame_d = frame_q + 16'd1;
          busy_d  = 1'b1;
        end else begin
          cnt_d     = nxt_idx_s;
          wr_en_d   = 1'b1;
          wr_idx_d  = nxt_idx_s;
          wr_data_d = nxt_word_s;
          busy_d    = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shadow_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_idx_q  <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      frame_q   <= 16'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      wr_en_q   <= wr_en_d;
      wr_idx_q  <= wr_idx_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      frame_q   <= frame_d;
    end
  end

  assign wr_en_o     = wr_en_q;
  assign wr_idx_o    = wr_idx_q;
  assign wr_data_o   = wr_data_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign frame_cnt_o = frame_q;

endmodule

// File: tb/tb_spiker_writer.sv
// Randomized scoreboard bench for spiker_writer: a frame-level model queues the expected
// word writes and done pulse on each accept; a monitor pops and compares as outputs appear.
module tb_spiker_writer;

  localparam int WIDTH    = 32;
  localparam int N_SPIKES = 784;
  localparam int N_WORDS  = 25;
  localparam int IDX_W    = 5;

  localparam int M_IDLE  = 0;
  localparam int M_WRITE = 1;
  localparam int M_DONE  = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                enable_i = 1'b0;
  logic                result_valid_i = 1'b0;
  logic [N_SPIKES-1:0] result_i = '0;
  logic                result_ready_o;
  logic                wr_en_o;
  logic [IDX_W-1:0]    wr_idx_o;
  logic [WIDTH-1:0]    wr_data_o;
  logic                busy_o;
  logic                done_o;
  logic [15:0]         frame_cnt_o;

  spiker_writer #(.WIDTH(WIDTH), .N_SPIKES(N_SPIKES)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .enable_i       (enable_i),
    .result_valid_i (result_valid_i),
    .result_i       (result_i),
    .result_ready_o (result_ready_o),
    .wr_en_o        (wr_en_o),
    .wr_idx_o       (wr_idx_o),
    .wr_data_o      (wr_data_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .frame_cnt_o    (frame_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_done;
    int          idx;
    logic [31:0] data;
    logic [15:0] frame;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   mst    = M_IDLE;
  int   mpos   = 0;
  logic [15:0] mframe = 16'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word k of the vector, counting bits beyond the vector as zero.
  function automatic logic [WIDTH-1:0] exp_word(input logic [N_SPIKES-1:0] v, input int k);
    logic [WIDTH-1:0] w;
    for (int b = 0; b < WIDTH; b++) begin
      int pos;
      pos  = k * WIDTH + b;
      w[b] = (pos < N_SPIKES) ? v[pos] : 1'b0;
    end
    return w;
  endfunction

  function automatic logic [N_SPIKES-1:0] rand_vec();
    logic [N_SPIKES-1:0] v;
    for (int i = 0; i < N_SPIKES; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  // One clock of stimulus: check cycle-level outputs against the model, then advance it.
  task automatic step(input logic en, input logic vld, input logic [N_SPIKES-1:0] vec);
    exp_t e;
    @(negedge clk);
    enable_i       = en;
    result_valid_i = vld;
    result_i       = vec;
    #1;
    chk("ready", 64'(result_ready_o), 64'((mst == M_IDLE) && en));
    chk("busy", 64'(busy_o), 64'(mst != M_IDLE));
    chk("wr_en_timing", 64'(wr_en_o), 64'(mst == M_WRITE));
    chk("done_timing", 64'(done_o), 64'(mst == M_DONE));
    chk("frame_cnt", 64'(frame_cnt_o), 64'(mframe));
    case (mst)
      M_IDLE: begin
        if (en && vld) begin
          for (int k = 0; k < N_WORDS; k++) begin
            e.is_done = 1'b0; e.idx = k; e.data = exp_word(vec, k); e.frame = 16'd0;
            exp_q.push_back(e);
          end
          e.is_done = 1'b1; e.idx = 0; e.data = 32'd0; e.frame = mframe + 16'd1;
          exp_q.push_back(e);
          mpos = 0;
          mst  = M_WRITE;
        end
      end
      M_WRITE: begin
        if (!en) begin
          repeat (N_WORDS - mpos) exp_q.delete(exp_q.size() - 1);
          mst = M_IDLE;
        end else if (mpos == N_WORDS - 1) begin
          mst    = M_DONE;
          mframe = mframe + 16'd1;
        end else begin
          mpos++;
        end
      end
      default: mst = M_IDLE;
    endcase
  endtask

  // Scoreboard monitor: every write strobe or done pulse consumes one expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n) begin
      if (wr_en_o || done_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", {62'd0, wr_en_o, done_o}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          if (wr_en_o) begin
            chk("kind_write", 64'(e.is_done), 64'd0);
            chk("wr_idx", 64'(wr_idx_o), 64'(e.idx));
            chk("wr_data", 64'(wr_data_o), 64'(e.data));
          end else begin
            chk("kind_done", 64'(e.is_done), 64'd1);
            chk("done_frame", 64'(frame_cnt_o), 64'(e.frame));
          end
        end
      end else begin
        chk("idle_idx_zero", 64'(wr_idx_o), 64'd0);
        chk("idle_data_zero", 64'(wr_data_o), 64'd0);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_wr_en"}, 64'(wr_en_o), 64'd0);
    chk({tag, "_wr_idx"}, 64'(wr_idx_o), 64'd0);
    chk({tag, "_wr_data"}, 64'(wr_data_o), 64'd0);
    chk({tag, "_busy"}, 64'(busy_o), 64'd0);
    chk({tag, "_done"}, 64'(done_o), 64'd0);
    chk({tag, "_frame"}, 64'(frame_cnt_o), 64'd0);
  endtask

  logic [N_SPIKES-1:0] alt_v;
  logic [N_SPIKES-1:0] v;

  initial begin
    for (int i = 0; i < N_SPIKES; i++) alt_v[i] = 1'(i % 2);

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Alternating pattern, valid for a single cycle.
    step(1'b1, 1'b1, alt_v);
    repeat (N_WORDS + 4) step(1'b1, 1'b0, rand_vec());

    // Valid held high: back-to-back frames spaced by the frame period.
    v = rand_vec();
    repeat (3 * (N_WORDS + 2)) step(1'b1, 1'b1, v);
    step(1'b1, 1'b0, v);

    // Random traffic with data changing every cycle and occasional enable drops.
    for (int c = 0; c < 1500; c++) begin
      step(($urandom_range(0, 99) < 97), 1'($urandom_range(0, 1)), rand_vec());
    end
    repeat (N_WORDS + 3) step(1'b1, 1'b0, '0);

    // Enable dropped while word 9 is on the write port.
    step(1'b1, 1'b1, rand_vec());
    for (int i = 0; i < 40 && !(mst == M_WRITE && mpos == 9); i++) step(1'b1, 1'b0, rand_vec());
    repeat (6) step(1'b0, 1'b1, rand_vec());
    repeat (3) step(1'b1, 1'b0, rand_vec());

    // Asynchronous reset while word 12 is on the write port.
    step(1'b1, 1'b1, rand_vec());
    for (int i = 0; i < 40 && !(mst == M_WRITE && mpos == 12); i++) step(1'b1, 1'b0, rand_vec());
    @(posedge clk);
    #2;
    chk("pre_reset_idx", 64'(wr_idx_o), 64'd12);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_q.delete();
    mst    = M_IDLE;
    mpos   = 0;
    mframe = 16'd0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b1, rand_vec());
    repeat (N_WORDS + 3) step(1'b1, 1'b0, rand_vec());

    // Frame counter wrap from 0xFFFF to 0.
    @(posedge clk);
    #2;
    force dut.frame_q = 16'hFFFE;
    #1;
    release dut.frame_q;
    mframe = 16'hFFFE;
    repeat (2) begin
      step(1'b1, 1'b1, rand_vec());
      repeat (N_WORDS + 2) step(1'b1, 1'b0, rand_vec());
    end
    chk("wrap_frame", 64'(frame_cnt_o), 64'd0);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
